systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_pkg.sv | 16 +
 rtl/systolic_ctrl.sv | 149 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants for the systolic-array controller: state encoding, default
// array dimension and the element-index width.
package systolic_pkg;

    localparam int DIM_DEF = 8;
    localparam int IDX_W   = 5;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_FEED  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/systolic_ctrl.sv
// Systolic-array sequencer: forwards decoded buffer writes while idle and runs
// CLEAR/FEED/DRAIN/DONE for a matrix multiply. Busy-cycle counter behind SYSTOLIC_PERF_CNT_EN.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DIM = DIM_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wen_a_i,
    input  logic        wen_b_i,
    input  logic        wen_c_i,
    input  logic [4:0]  row_i,
    input  logic [4:0]  col_i,
    input  logic [31:0] data_i,
    input  logic        start_i,
    output logic        arr_wen_a_o,
    output logic        arr_wen_b_o,
    output logic        arr_wen_c_o,
    output logic [4:0]  arr_row_o,
    output logic [4:0]  arr_col_o,
    output logic [31:0] arr_data_o,
    output logic        arr_clear_o,
    output logic        arr_shift_o,
    output logic        arr_feed_vld_o,
    output logic [4:0]  feed_idx_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] cyc_cnt_o
);

    localparam logic [IDX_W-1:0] DIM_L      = IDX_W'(DIM);
    localparam logic [IDX_W-1:0] FEED_LAST  = IDX_W'(2*DIM-2);
    localparam logic [IDX_W-1:0] DRAIN_LAST = IDX_W'(DIM-1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   cnt, cnt_nx;
    logic               busy, any_wen, in_rng, wr_ok, wr_bad;

    assign busy    = (state != S_IDLE);
    assign any_wen = wen_a_i | wen_b_i | wen_c_i;
    assign in_rng  = (row_i < DIM_L) && (col_i < DIM_L);
    assign wr_ok   = !busy && in_rng;
    assign wr_bad  = !busy && any_wen && !in_rng;

    // Requests arriving while busy are held by decode and replayed later.
    assign stall_o = busy & (start_i | any_wen);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nx = S_CLEAR;
                    cnt_nx   = '0;
                end
            end
            S_CLEAR: begin
                state_nx = S_FEED;
                cnt_nx   = '0;
            end
            S_FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A write accepted together with start still lands in the cycle after,
    // while CLEAR runs; CLEAR only touches the accumulators.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            arr_wen_a_o <= 1'b0;
            arr_wen_b_o <= 1'b0;
            arr_wen_c_o <= 1'b0;
            arr_row_o   <= '0;
            arr_col_o   <= '0;
            arr_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            arr_wen_a_o <= wr_ok & wen_a_i;
            arr_wen_b_o <= wr_ok & wen_b_i;
            arr_wen_c_o <= wr_ok & wen_c_i;
            if (wr_ok && any_wen) begin
                arr_row_o  <= row_i;
                arr_col_o  <= col_i;
                arr_data_o <= data_i;
            end
            err_o <= err_o | wr_bad;
        end
    end

    assign busy_o         = busy;
    assign arr_clear_o    = (state == S_CLEAR);
    assign arr_shift_o    = (state == S_FEED) || (state == S_DRAIN);
    assign arr_feed_vld_o = (state == S_FEED);
    assign feed_idx_o     = (state == S_FEED) ? cnt : '0;
    assign done_o         = (state == S_DONE);

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_cnt <= '0;
        end else if (busy && (cyc_cnt != 32'hFFFF_FFFF)) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    assign cyc_cnt_o = cyc_cnt;
`else
    assign cyc_cnt_o = '0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl (DIM=8): scoreboarded write forwarding,
// operation timing, stalls, range errors, async reset and the busy-cycle counter.
module tb_systolic_ctrl;
    localparam int DIM = 8;

    logic        clk, rst_n;
    logic        wen_a, wen_b, wen_c, start;
    logic [4:0]  row, col;
    logic [31:0] data;
    logic        arr_wen_a, arr_wen_b, arr_wen_c;
    logic [4:0]  arr_row, arr_col;
    logic [31:0] arr_data;
    logic        arr_clear, arr_shift, arr_feed_vld;
    logic [4:0]  feed_idx;
    logic        busy, stall, done, err;
    logic [31:0] cyc_cnt;

    typedef struct packed {
        logic        a, b, c;
        logic [4:0]  row, col;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    systolic_ctrl #(.DIM(DIM)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wen_a_i(wen_a), .wen_b_i(wen_b), .wen_c_i(wen_c),
        .row_i(row), .col_i(col), .data_i(data), .start_i(start),
        .arr_wen_a_o(arr_wen_a), .arr_wen_b_o(arr_wen_b), .arr_wen_c_o(arr_wen_c),
        .arr_row_o(arr_row), .arr_col_o(arr_col), .arr_data_o(arr_data),
        .arr_clear_o(arr_clear), .arr_shift_o(arr_shift), .arr_feed_vld_o(arr_feed_vld),
        .feed_idx_o(feed_idx), .busy_o(busy), .stall_o(stall), .done_o(done),
        .err_o(err), .cyc_cnt_o(cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every forwarded array write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && (arr_wen_a || arr_wen_b || arr_wen_c)) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", {arr_wen_a, arr_wen_b, arr_wen_c}, 0);
            end else begin
                chk("sb_write", {arr_wen_a, arr_wen_b, arr_wen_c, arr_row, arr_col, arr_data},
                    exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        wen_a = 0; wen_b = 0; wen_c = 0; start = 0;
        row = 0; col = 0; data = 0;
    endtask

    task automatic do_write(input logic a, input logic b, input logic c,
                            input logic [4:0] r, input logic [4:0] cl, input logic [31:0] d);
        wr_t w;
        @(posedge clk); #1;
        wen_a = a; wen_b = b; wen_c = c; row = r; col = cl; data = d;
        if (r < DIM && cl < DIM) begin
            w = '{a: a, b: b, c: c, row: r, col: cl, data: d};
            exp_q.push_back(w);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);
        chk("rst_cyc", cyc_cnt, 0);
        chk("rst_arr", {arr_wen_a, arr_wen_b, arr_wen_c, arr_row, arr_col, arr_data,
                        arr_clear, arr_shift, arr_feed_vld, feed_idx}, 0);
        #2 rst_n = 1;

        // Single A write, checked directly as well as through the scoreboard.
        @(posedge clk); #1;
        wen_a = 1; row = 3; col = 5; data = 32'hDEAD;
        exp_q.push_back('{a: 1, b: 0, c: 0, row: 3, col: 5, data: 32'hDEAD});
        @(posedge clk); #1;
        idle_inputs();
        chk("wr_a_wen", arr_wen_a, 1);
        chk("wr_a_row", arr_row, 3);
        chk("wr_a_col", arr_col, 5);
        chk("wr_a_data", arr_data, 32'hDEAD);

        do_write(1, 1, 1, 5'd7, 5'd7, 32'h1234_5678);
        do_write(0, 1, 0, 5'd0, 5'd0, 32'hCAFE_F00D);
        do_write(0, 0, 1, 5'd7, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("err_clean", err, 0);

        // Full operation, start in cycle 0; one FEED-cycle B write must stall.
        @(posedge clk); #1;
        start = 1;
        @(negedge clk);
        chk("start_idle_stall", stall, 0);
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk); #1;
            start = 0;
            wen_b = (c == 5);
            row = 1; col = 1; data = 32'hBAD0_0000;
            @(negedge clk);
            chk($sformatf("busy_c%0d", c), busy, (c <= 25));
            chk($sformatf("clear_c%0d", c), arr_clear, (c == 1));
            chk($sformatf("shift_c%0d", c), arr_shift, (c >= 2 && c <= 24));
            chk($sformatf("fvld_c%0d", c), arr_feed_vld, (c >= 2 && c <= 16));
            chk($sformatf("fidx_c%0d", c), feed_idx, (c >= 2 && c <= 16) ? c - 2 : 0);
            chk($sformatf("done_c%0d", c), done, (c == 25));
            if (c == 5) chk("feed_wr_stall", stall, 1);
        end
        idle_inputs();
`ifdef SYSTOLIC_PERF_CNT_EN
        chk("cyc_cnt_op", cyc_cnt, 25);
`else
        chk("cyc_cnt_off", cyc_cnt, 0);
`endif

        // Write and start together: write is forwarded, start is accepted.
        @(posedge clk); #1;
        wen_a = 1; start = 1; row = 1; col = 2; data = 32'h0000_ABCD;
        exp_q.push_back('{a: 1, b: 0, c: 0, row: 1, col: 2, data: 32'h0000_ABCD});
        @(posedge clk); #1;
        idle_inputs();
        chk("wr_start_busy", busy, 1);
        chk("wr_start_clear", arr_clear, 1);
        wait_idle();

        // Start held across the DONE cycle: stalled there, accepted in IDLE.
        @(posedge clk); #1;
        start = 1;
        for (int c = 1; c <= 25; c++) @(posedge clk);
        @(negedge clk);
        chk("done_hold", done, 1);
        chk("done_start_stall", stall, 1);
        @(negedge clk);
        chk("after_done_idle", busy, 0);
        chk("after_done_stall", stall, 0);
        @(posedge clk); #1;
        start = 0;
        chk("restart_busy", busy, 1);
        chk("restart_clear", arr_clear, 1);
        wait_idle();

        // Out-of-range write: dropped, err sticky.
        do_write(0, 0, 1, 5'd8, 5'd0, 32'h5555_5555);
        @(negedge clk);
        chk("err_set", err, 1);
        do_write(1, 0, 0, 5'd2, 5'd31, 32'h6666_6666);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);

        // Async reset at FEED step 10.
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (11) @(posedge clk);
        #1;
        chk("pre_rst_fidx", feed_idx, 10);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        chk("arst_cyc", cyc_cnt, 0);
        chk("arst_arr", {arr_wen_a, arr_wen_b, arr_wen_c, arr_row, arr_col, arr_data,
                         arr_clear, arr_shift, arr_feed_vld, feed_idx, done, stall}, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_shift", arr_shift, 0);

        do_write(0, 1, 0, 5'd4, 5'd6, 32'h0BAD_BEEF);
        repeat (2) @(negedge clk);
        chk("sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
